// File: rtl/cert_chain_responder_pkg.sv
// Shared constants, state encoding and helpers for the GET_CERTIFICATE responder.
package cert_chain_responder_pkg;

  localparam int DEF_CHUNK_BYTES = 16;
  localparam int DEF_ADDR_W      = 12;

  localparam logic [7:0] PROTOCOL_VERSION = 8'h01;

  localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] MSG_CERTIFICATE     = 8'h02;
  localparam logic [7:0] MSG_ERROR           = 8'h7F;

  localparam logic [7:0] ERR_NONE                 = 8'h00;
  localparam logic [7:0] ERR_INVALID_REQUEST      = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED_PROTOCOL = 8'h02;
  localparam logic [7:0] ERR_UNEXPECTED_REQUEST   = 8'h04;

  // Byte lanes of a message header.
  localparam int HDR_VERSION_LSB  = 0;
  localparam int HDR_MSG_TYPE_LSB = 8;
  localparam int HDR_PARAM1_LSB   = 16;
  localparam int HDR_PARAM2_LSB   = 24;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DECODE       = 3'd1,
    ST_FETCH        = 3'd2,
    ST_RESPOND      = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  // Bytes served: smallest of requested length, chunk limit and bytes left in the chain.
  function automatic logic [15:0] chunk_len(input logic [15:0] length,
                                            input logic [15:0] max_chunk,
                                            input logic [15:0] remaining);
    logic [15:0] n;
    n = length;
    if (max_chunk < n) n = max_chunk;
    if (remaining < n) n = remaining;
    return n;
  endfunction

  // Assemble a response header in the same byte layout as a request header.
  function automatic logic [31:0] build_header(input logic [7:0] param2,
                                               input logic [7:0] param1,
                                               input logic [7:0] msg_type);
    return {param2, param1, msg_type, PROTOCOL_VERSION};
  endfunction

endpackage

// File: rtl/cert_chain_responder_fetcher.sv
// Reads one chunk of certificate bytes from byte-wide storage into the payload buffer.
module cert_chunk_fetcher
  import cert_chain_responder_pkg::*;
#(
  parameter int CHUNK_BYTES = DEF_CHUNK_BYTES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CNT_W       = $clog2(DEF_CHUNK_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         count,
  input  logic [7:0]               cert_data,
  output logic                     cert_rd_en,
  output logic [ADDR_W-1:0]        cert_addr,
  output logic [8*CHUNK_BYTES-1:0] payload,
  output logic                     done
);

  localparam int IDX_W = $clog2(CHUNK_BYTES);

  logic                     busy;
  logic [CNT_W-1:0]         idx;
  logic [CNT_W-1:0]         last_idx;
  logic                     cap_valid;
  logic [IDX_W-1:0]         cap_idx;
  logic [8*CHUNK_BYTES-1:0] buffer;

  assign last_idx = count - {{(CNT_W-1){1'b0}}, 1'b1};
  assign payload  = buffer;

  // Issue counter: walks idx 0..count-1, one read per cycle, after a start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      idx  <= {CNT_W{1'b0}};
    end else if (start) begin
      busy <= 1'b1;
      idx  <= {CNT_W{1'b0}};
    end else if (busy) begin
      if (idx == last_idx) busy <= 1'b0;
      idx <= idx + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Track which byte lane the storage answers into on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_idx   <= {IDX_W{1'b0}};
    end else begin
      cap_valid <= busy;
      cap_idx   <= idx[IDX_W-1:0];
    end
  end

  // Payload buffer: zeroed when a new request is accepted, then filled byte by byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer <= {(8*CHUNK_BYTES){1'b0}};
    end else if (clear) begin
      buffer <= {(8*CHUNK_BYTES){1'b0}};
    end else if (cap_valid) begin
      buffer[{cap_idx, 3'b000} +: 8] <= cert_data;
    end
  end

  // Read strobe/address decode; done marks the cycle issuing the final read.
  always_comb begin
    cert_rd_en = busy;
    cert_addr  = {ADDR_W{1'b0}};
    done       = 1'b0;
    if (busy) begin
      cert_addr = base_addr + ADDR_W'(idx);
      done      = (idx == last_idx);
    end else begin
      cert_addr = {ADDR_W{1'b0}};
      done      = 1'b0;
    end
  end

endmodule

// File: rtl/cert_chain_responder.sv
// GET_CERTIFICATE responder: request handshake, validation, chunk fetch and response.
module cert_chain_responder
  import cert_chain_responder_pkg::*;
#(
  parameter int CHUNK_BYTES = DEF_CHUNK_BYTES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Enable,
  input  logic [31:0]              req_header,
  input  logic [31:0]              req_payload,
  input  logic                     Ack_in,
  input  logic [3:0]               slot_valid,
  input  logic [15:0]              chain_len,
  output logic [1:0]               cert_slot,
  output logic                     cert_rd_en,
  output logic [ADDR_W-1:0]        cert_addr,
  input  logic [7:0]               cert_data,
  output logic [31:0]              header,
  output logic [8*CHUNK_BYTES-1:0] payload,
  output logic [15:0]              resp_bytes,
  output logic                     Ack_out,
  output logic                     error
);

  localparam int CNT_W = $clog2(CHUNK_BYTES + 1);

  state_t      state;
  state_t      next_state;
  logic        capture;
  logic [7:0]  ver_q;
  logic [7:0]  type_q;
  logic [5:0]  p1_hi_q;
  logic [15:0] len_q;
  logic [15:0] off_q;
  logic [7:0]  code_q;
  logic [15:0] n_q;
  logic        start_q;
  logic [7:0]  dec_code;
  logic [15:0] dec_n;
  logic        fetch_done;
  logic        unused_param2;

  // Param2 carries nothing for GET_CERTIFICATE.
  assign unused_param2 = ^req_header[HDR_PARAM2_LSB +: 8];
  assign capture       = (state == ST_IDLE) && Enable && Ack_in;

  // Header/range validation; the first failing check decides the error code.
  always_comb begin
    dec_code = ERR_NONE;
    dec_n    = 16'd0;
    if (ver_q != PROTOCOL_VERSION) begin
      dec_code = ERR_UNSUPPORTED_PROTOCOL;
    end else if (type_q != MSG_GET_CERTIFICATE) begin
      dec_code = ERR_UNEXPECTED_REQUEST;
    end else if ((p1_hi_q != 6'd0) || !slot_valid[cert_slot] ||
                 (len_q == 16'd0) || (off_q >= chain_len)) begin
      dec_code = ERR_INVALID_REQUEST;
    end else begin
      dec_code = ERR_NONE;
      dec_n    = chunk_len(len_q, 16'(CHUNK_BYTES), chain_len - off_q);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:         if (capture) next_state = ST_DECODE;
                       else         next_state = ST_IDLE;
      ST_DECODE:       if (dec_code != ERR_NONE) next_state = ST_RESPOND;
                       else                      next_state = ST_FETCH;
      ST_FETCH:        if (fetch_done) next_state = ST_RESPOND;
                       else            next_state = ST_FETCH;
      ST_RESPOND:      next_state = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (!Ack_in) next_state = ST_IDLE;
                       else         next_state = ST_WAIT_RELEASE;
      default:         next_state = ST_IDLE;
    endcase
  end

  // Latch the request on acceptance and the decode verdict one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      ver_q     <= 8'h00;
      type_q    <= 8'h00;
      p1_hi_q   <= 6'd0;
      len_q     <= 16'd0;
      off_q     <= 16'd0;
      cert_slot <= 2'd0;
      code_q    <= ERR_NONE;
      n_q       <= 16'd0;
      start_q   <= 1'b0;
    end else begin
      if (capture) begin
        ver_q     <= req_header[HDR_VERSION_LSB +: 8];
        type_q    <= req_header[HDR_MSG_TYPE_LSB +: 8];
        p1_hi_q   <= req_header[HDR_PARAM1_LSB + 2 +: 6];
        cert_slot <= req_header[HDR_PARAM1_LSB +: 2];
        off_q     <= req_payload[15:0];
        len_q     <= req_payload[31:16];
      end
      if (state == ST_DECODE) begin
        code_q <= dec_code;
        n_q    <= dec_n;
      end
      start_q <= (state == ST_DECODE) && (dec_code == ERR_NONE);
    end
  end

  // Response registers: loaded leaving RESPOND, dropped once the initiator releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      header     <= 32'h0000_0000;
      resp_bytes <= 16'd0;
      Ack_out    <= 1'b0;
      error      <= 1'b0;
    end else if (state == ST_RESPOND) begin
      Ack_out <= 1'b1;
      if (code_q != ERR_NONE) begin
        header     <= build_header(8'h00, code_q, MSG_ERROR);
        resp_bytes <= 16'd0;
        error      <= 1'b1;
      end else begin
        header     <= build_header(8'h00, {6'd0, cert_slot}, MSG_CERTIFICATE);
        resp_bytes <= n_q;
        error      <= 1'b0;
      end
    end else if ((state == ST_WAIT_RELEASE) && !Ack_in) begin
      Ack_out <= 1'b0;
      error   <= 1'b0;
    end
  end

  cert_chunk_fetcher #(
    .CHUNK_BYTES (CHUNK_BYTES),
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W)
  ) u_fetcher (
    .clk        (clk),
    .reset      (reset),
    .clear      (capture),
    .start      (start_q),
    .base_addr  (off_q[ADDR_W-1:0]),
    .count      (n_q[CNT_W-1:0]),
    .cert_data  (cert_data),
    .cert_rd_en (cert_rd_en),
    .cert_addr  (cert_addr),
    .payload    (payload),
    .done       (fetch_done)
  );

endmodule

// File: tb/tb_cert_chain_responder.sv
// Directed bench for cert_chain_responder with a byte-wide storage model.
module tb_cert_chain_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         Enable;
  logic [31:0]  req_header;
  logic [31:0]  req_payload;
  logic         Ack_in;
  logic [3:0]   slot_valid;
  logic [15:0]  chain_len;
  logic [1:0]   cert_slot;
  logic         cert_rd_en;
  logic [11:0]  cert_addr;
  logic [7:0]   cert_data = 8'h00;
  logic [31:0]  header;
  logic [127:0] payload;
  logic [15:0]  resp_bytes;
  logic         Ack_out;
  logic         error;

  logic [15:0]  chain_tab [4];
  logic [11:0]  addr_log [256];
  int           rd_cnt = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           lat;
  int           rd_base;

  always #5 clk = ~clk;

  cert_chain_responder dut (
    .clk(clk), .reset(reset), .Enable(Enable), .req_header(req_header),
    .req_payload(req_payload), .Ack_in(Ack_in), .slot_valid(slot_valid),
    .chain_len(chain_len), .cert_slot(cert_slot), .cert_rd_en(cert_rd_en),
    .cert_addr(cert_addr), .cert_data(cert_data), .header(header),
    .payload(payload), .resp_bytes(resp_bytes), .Ack_out(Ack_out), .error(error)
  );

  assign chain_len = chain_tab[cert_slot];

  function automatic logic [7:0] mem_byte(input logic [1:0] slot, input logic [11:0] addr);
    logic [7:0] b;
    b = addr[7:0] + {addr[11:8], 4'h0};
    b = b ^ {6'd0, slot} ^ 8'hA5;
    return b;
  endfunction

  function automatic logic [127:0] exp_pay(input logic [1:0] slot, input int off, input int n);
    logic [127:0] p;
    p = 128'd0;
    for (int i = 0; i < 16; i++)
      if (i < n) p[8*i +: 8] = mem_byte(slot, 12'(off + i));
    return p;
  endfunction

  // Storage: answers a read strobe with data one cycle later.
  always @(posedge clk)
    if (cert_rd_en === 1'b1) cert_data <= mem_byte(cert_slot, cert_addr);

  // Log every issued read address.
  always @(negedge clk)
    if (cert_rd_en === 1'b1) begin
      addr_log[rd_cnt & 255] = cert_addr;
      rd_cnt = rd_cnt + 1;
    end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns edges after capture edge E at which Ack_out is first seen.
  task automatic send(input logic [31:0] h, input logic [31:0] p, input bit drop_en,
                      output int l);
    rd_base     = rd_cnt;
    req_header  = h;
    req_payload = p;
    Ack_in      = 1'b1;
    l = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (drop_en && k == 0) Enable = 1'b0;
      if (Ack_out === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic release_ack(input int hold, input string tag);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk({tag, "_held"}, 128'(Ack_out), 128'd1);
    Ack_in = 1'b0;
    @(negedge clk);
    chk({tag, "_release"}, 128'(Ack_out), 128'd0);
  endtask

  initial begin
    chain_tab[0] = 16'd40;
    chain_tab[1] = 16'd40;
    chain_tab[2] = 16'd40;
    chain_tab[3] = 16'd300;
    reset = 1'b1; Enable = 1'b0; Ack_in = 1'b0;
    req_header = 32'h0; req_payload = 32'h0; slot_valid = 4'b1001;
    repeat (3) @(negedge clk);
    chk("rst_ack", 128'(Ack_out), 128'd0);
    chk("rst_err", 128'(error), 128'd0);
    chk("rst_hdr", 128'(header), 128'd0);
    chk("rst_pay", payload, 128'd0);
    chk("rst_bytes", 128'(resp_bytes), 128'd0);
    chk("rst_rd", 128'({cert_rd_en, cert_slot, cert_addr}), 128'd0);
    reset = 1'b0;
    Enable = 1'b1;
    @(negedge clk);

    // Full 16-byte chunk from offset 0.
    send(32'h0000_8201, {16'd16, 16'd0}, 1'b0, lat);
    chk("a_lat", 128'(lat), 128'd19);
    chk("a_hdr", 128'(header), 128'h0000_0201);
    chk("a_bytes", 128'(resp_bytes), 128'd16);
    chk("a_err", 128'(error), 128'd0);
    chk("a_pay", payload, exp_pay(2'd0, 0, 16));
    chk("a_rdcnt", 128'(rd_cnt - rd_base), 128'd16);
    chk("a_addr0", 128'(addr_log[rd_base & 255]), 128'd0);
    release_ack(5, "a");
    chk("a_hdr_keep", 128'(header), 128'h0000_0201);

    // Back-to-back: tail of chain, Enable dropped mid-exchange.
    send(32'h0000_8201, {16'd16, 16'd32}, 1'b1, lat);
    Enable = 1'b1;
    chk("b_lat", 128'(lat), 128'd11);
    chk("b_bytes", 128'(resp_bytes), 128'd8);
    chk("b_pay", payload, exp_pay(2'd0, 32, 8));
    chk("b_rdcnt", 128'(rd_cnt - rd_base), 128'd8);
    chk("b_addr0", 128'(addr_log[rd_base & 255]), 128'd32);
    chk("b_addr7", 128'(addr_log[(rd_base + 7) & 255]), 128'd39);
    release_ack(0, "b");

    // Offset at end of chain.
    send(32'h0000_8201, {16'd16, 16'd40}, 1'b0, lat);
    chk("c_lat", 128'(lat), 128'd2);
    chk("c_hdr", 128'(header), 128'h0001_7F01);
    chk("c_err", 128'(error), 128'd1);
    chk("c_bytes", 128'(resp_bytes), 128'd0);
    chk("c_pay", payload, 128'd0);
    chk("c_rdcnt", 128'(rd_cnt - rd_base), 128'd0);
    release_ack(0, "c");
    chk("c_err_clr", 128'(error), 128'd0);

    // Header errors.
    send(32'h0000_8202, {16'd16, 16'd0}, 1'b0, lat);
    chk("d_ver", 128'({lat[7:0], header}), {88'd0, 8'd2, 32'h0002_7F01});
    release_ack(0, "d");
    send(32'h0000_8101, {16'd16, 16'd0}, 1'b0, lat);
    chk("e_type", 128'({lat[7:0], header}), {88'd0, 8'd2, 32'h0004_7F01});
    release_ack(0, "e");
    send(32'h0002_8201, {16'd16, 16'd0}, 1'b0, lat);
    chk("f_slot", 128'({cert_slot, header}), {94'd0, 2'd2, 32'h0001_7F01});
    release_ack(0, "f");
    send(32'h0004_8201, {16'd16, 16'd0}, 1'b0, lat);
    chk("g_p1hi", 128'(header), 128'h0001_7F01);
    release_ack(0, "g");
    send(32'h0000_8201, {16'd0, 16'd0}, 1'b0, lat);
    chk("h_len0", 128'({error, header}), {95'd0, 1'b1, 32'h0001_7F01});
    release_ack(0, "h");

    // Slot 3, long chain, addresses crossing 256.
    send(32'h0003_8201, {16'd10, 16'd250}, 1'b0, lat);
    chk("i_lat", 128'(lat), 128'd13);
    chk("i_hdr", 128'(header), 128'h0003_0201);
    chk("i_bytes", 128'(resp_bytes), 128'd10);
    chk("i_pay", payload, exp_pay(2'd3, 250, 10));
    chk("i_addr9", 128'(addr_log[(rd_base + 9) & 255]), 128'd259);
    release_ack(0, "i");

    // Request with Enable low is ignored.
    Enable = 1'b0;
    rd_base = rd_cnt;
    Ack_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("j_ignored", 128'({Ack_out, 31'(rd_cnt - rd_base)}), 128'd0);
    Ack_in = 1'b0;
    Enable = 1'b1;
    @(negedge clk);

    // Reset during FETCH, then a clean request.
    req_header = 32'h0003_8201;
    req_payload = {16'd16, 16'd0};
    Ack_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("k_in_fetch", 128'(cert_rd_en), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("k_rst_out", 128'({Ack_out, error, header, resp_bytes, cert_slot, cert_rd_en, cert_addr}), 128'd0);
    chk("k_rst_pay", payload, 128'd0);
    reset = 1'b0;
    Ack_in = 1'b0;
    @(negedge clk);
    chk("k_no_rd", 128'(cert_rd_en), 128'd0);
    send(32'h0000_8201, {16'd5, 16'd3}, 1'b0, lat);
    chk("k_lat", 128'(lat), 128'd8);
    chk("k_hdr", 128'(header), 128'h0000_0201);
    chk("k_pay", payload, exp_pay(2'd0, 3, 5));
    release_ack(0, "k");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cert_chain_responder.md
# cert_chain_responder

Responder side of the USB Type-C Authentication GET_CERTIFICATE exchange. Accepts one GET_CERTIFICATE request per 4-phase handshake and validates header and offset/length. Reads the requested chunk of the selected slot's certificate chain from byte-wide storage and returns either a CERTIFICATE response or an ERROR response. Sits between the authentication message channel and the certificate storage, opposite the initiator's certificate control FSM.

## Interface
- CHUNK_BYTES, 16, maximum certificate bytes returned per response
- ADDR_W, 12, byte-address width within one slot's chain
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Enable  in  1  responder armed; sampled only in IDLE
- req_header  in  32  {Param2[31:24], Param1[23:16], MessageType[15:8], ProtocolVersion[7:0]}
- req_payload  in  32  {Length[31:16], Offset[15:0]}
- Ack_in  in  1  request valid, held high until Ack_out seen
- slot_valid  in  4  bit s set = slot s provisioned
- chain_len  in  16  chain length in bytes of slot on cert_slot (combinational lookup)
- cert_slot  out  2  slot being served
- cert_rd_en  out  1  storage read strobe
- cert_addr  out  ADDR_W  byte address within slot
- cert_data  in  8  read data, valid the cycle after cert_rd_en
- header  out  32  response header, same byte layout as req_header
- payload  out  8*CHUNK_BYTES  byte i at bits [8i+7:8i], unused bytes zero
- resp_bytes  out  16  valid payload bytes
- Ack_out  out  1  response valid
- error  out  1  high with Ack_out when response is ERROR

## Operation
- States: IDLE, DECODE, FETCH, RESPOND, WAIT_RELEASE.
- IDLE: if Enable && Ack_in, register req_header/req_payload, cert_slot <= Param1[1:0], go DECODE. Otherwise stay.
- DECODE checks, first failing wins:
  - ProtocolVersion != 8'h01 -> code 8'h02
  - MessageType != 8'h82 -> code 8'h04
  - Param1[7:2] != 0, or !slot_valid[slot], or Length == 0, or Offset >= chain_len -> code 8'h01
  - On failure go RESPOND; on pass go FETCH.
- n = min(Length, CHUNK_BYTES, chain_len - Offset). All arithmetic is 16-bit unsigned. The subtraction is evaluated only after Offset < chain_len.
- FETCH:
  - Issue counter i = 0..n-1: cert_rd_en = 1, cert_addr = Offset + i (low ADDR_W bits).
  - Each returned byte is written to payload byte i on the following edge.
  - Payload buffer is cleared on DECODE entry.
  - Go RESPOND once byte n-1 is captured.
- RESPOND: drive outputs, go WAIT_RELEASE.
  - Success: header = {8'h00, 6'b0, slot, 8'h02, 8'h01}, resp_bytes = n, error = 0.
  - Error: header = {8'h00, code, 8'h7F, 8'h01}, payload = 0, resp_bytes = 0, error = 1.
- WAIT_RELEASE: hold Ack_out, header, payload, resp_bytes and error until Ack_in is sampled low. Then Ack_out = 0, error = 0, go IDLE. header/payload hold their last values.
- Enable falling mid-transaction does not abort; the current exchange completes.

## Timing
- All outputs are registered except cert_rd_en and cert_addr, which decode from state and i.
- Reset values: Ack_out 0, error 0, header 0, payload 0, resp_bytes 0, cert_slot 0, cert_rd_en 0, cert_addr 0, state IDLE.
- Reset mid-transaction: everything returns to reset values on that edge. No read is issued in the following cycle.
- Let edge E be the IDLE edge that samples Ack_in high:
  - Success: Ack_out is high after edge E+3+n.
  - Error: Ack_out is high after edge E+2.
  - cert_rd_en is high in cycles after edges E+2 .. E+1+n.
- Release: Ack_out falls one edge after Ack_in is sampled low in WAIT_RELEASE. The earliest next capture is the edge after that.
- Ack_in high in IDLE with Enable low: ignored; no response.

## Structure
- Parameters.v (shared include) gets these constants:
  - protocol version 8'h01
  - message types GET_CERTIFICATE 8'h82, CERTIFICATE 8'h02, ERROR 8'h7F
  - error codes INVALID_REQUEST 8'h01, UNSUPPORTED_PROTOCOL 8'h02, UNEXPECTED_REQUEST 8'h04
  - header byte positions
- Sub-module cert_chunk_fetcher contains:
  - issue counter
  - read strobe/address generation
  - one-cycle-delayed byte capture into the payload buffer
  - done flag
- The top level keeps the FSM, validation and response formatting.

## Test plan
- Slot 0 valid, chain_len 40, Offset 0, Length 16 -> header 32'h00000201, resp_bytes 16, payload = bytes 0..15, Ack_out after E+19.
- Offset 32, Length 16, chain_len 40 -> n = 8, resp_bytes 8, payload bytes 8..15 zero, cert_addr 32..39.
- Offset 40, chain_len 40 -> ERROR header 32'h00017F01, error 1, no cert_rd_en, Ack_out after E+2.
- Version 8'h02 -> code 8'h02. MessageType 8'h81 -> code 8'h04. slot_valid 4'b0001 with slot 2 -> code 8'h01.
- Ack_in held high 5 cycles after Ack_out -> Ack_out held. Ack_in low -> Ack_out low next edge. Back-to-back request accepted.
- reset asserted during FETCH -> next cycle all outputs at reset values. A new request then completes normally.
